// File: rtl/signed_left_shift_saturating_iterative.sv
// Signed saturating left shift, one bit per clock.
// Computes a * 2^s for a signed N-bit operand. Signed overflow is detected
// along the way, and the result then saturates to the representable extreme
// that matches the operand's sign. Valid/ready handshakes on both sides.
module signed_left_shift_saturating_iterative #(
   parameter int N  = 8,
   parameter int SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  a,
   input  logic [SW-1:0] s,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  res,
   output logic          ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] MAX_NEG = {1'b1, {(N-1){1'b0}}};

   state_t        state;
   state_t        state_nxt;
   logic [N-1:0]  acc;
   logic [SW-1:0] cnt;
   logic          sign;
   logic          ovf_r;

   // State register.
   // NOTE: sequential state is assigned with <= so that every flop samples
   // pre-edge values; a blocking = here would create simulation order races.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   // NOTE: state_nxt gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)   state_nxt = SHIFT;
         SHIFT:   if (cnt == '0)  state_nxt = DONE;
         DONE:    if (out_ready)  state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   // Handshake outputs are pure decodes of the state.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Datapath: operand capture, one shift per SHIFT cycle, result load.
   // NOTE: the datapath registers are reset as well, because res and ovf
   // must read as zero after reset and must not be left unknown.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         cnt   <= '0;
         sign  <= 1'b0;
         ovf_r <= 1'b0;
         res   <= '0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  acc   <= a;
                  cnt   <= s;
                  sign  <= a[N-1];
                  ovf_r <= 1'b0;
               end
            end
            SHIFT: begin
               if (cnt == '0) begin
                  res <= ovf_r ? (sign ? MAX_NEG : MAX_POS) : acc;
                  ovf <= ovf_r;
               end else begin
                  // Losing a bit that differs from the new sign bit means
                  // the true product no longer fits; remember it. The
                  // remaining steps still run so latency depends only on s.
                  if (acc[N-1] != acc[N-2]) ovf_r <= 1'b1;
                  acc <= {acc[N-2:0], 1'b0};
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_signed_left_shift_saturating_iterative.sv
// Self-checking bench for signed_left_shift_saturating_iterative (N=8).
// A reference queue holds clamp(a*2^s) for every accepted operand; one
// compare process checks res/ovf against it whenever out_valid is high.
// Directed tests add hand-computed literal expectations and timing checks.
module tb_signed_left_shift_saturating_iterative;

   localparam int N  = 8;
   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  a;
   logic [SW-1:0] s;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  res;
   logic          ovf;

   int checks = 0;
   int errors = 0;

   logic [8:0] exp_q[$];   // {ovf, res}

   signed_left_shift_saturating_iterative #(.N(N), .SW(SW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .s         (s),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Exact product, then clamp to the signed 8-bit range.
   function automatic logic [8:0] model(input logic [7:0] av, input logic [2:0] sv);
      int p;
      p = int'($signed(av)) * (1 << sv);
      if (p > 127)  return {1'b1, 8'h7F};
      if (p < -128) return {1'b1, 8'h80};
      return {1'b0, p[7:0]};
   endfunction

   // Scoreboard bookkeeping on the active edge (pre-edge values).
   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
         if (in_valid && in_ready) exp_q.push_back(model(a, s));
      end
   end

   // Compare process: every cycle a result is presented.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         check("outstanding results", exp_q.size(), 1);
         if (exp_q.size() > 0) begin
            check("model res", res, exp_q[0][7:0]);
            check("model ovf", ovf, exp_q[0][8]);
         end
         check("in_ready low in DONE", in_ready, 0);
      end
   end

   // Input handshake plus latency check (out_valid first in cycle T+s+2).
   task automatic start_op(input logic [7:0] av, input logic [2:0] sv);
      int k;
      int lat;
      a = av;
      s = sv;
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 50) begin
         @(posedge clk); #1; k++;
      end
      check("in_ready wait", (k < 50), 1);
      @(posedge clk); #1;          // handshake edge ends cycle T
      in_valid = 1'b0;
      lat = 0;                     // now in cycle T+1
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      check("latency", lat, sv + 1);
   endtask

   // Output handshake after holding out_ready low for hold cycles.
   task automatic finish_op(input int hold);
      repeat (hold) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("out_valid drops", out_valid, 0);
      check("in_ready back", in_ready, 1);
   endtask

   task automatic op(input logic [7:0] av, input logic [2:0] sv,
                     input logic [7:0] er, input logic eo);
      start_op(av, sv);
      check("literal res", res, er);
      check("literal ovf", ovf, eo);
      finish_op(0);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      logic hs;
      rst = 1'b1; in_valid = 1'b0; a = '0; s = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset res", res, 8'h00);
      check("reset ovf", ovf, 0);

      // Pin the model with hand-computed values.
      check("model 3<<2", model(8'h03, 3'd2), {1'b0, 8'h0C});
      check("model 64<<1", model(8'h40, 3'd1), {1'b1, 8'h7F});
      check("model -1<<7", model(8'hFF, 3'd7), {1'b0, 8'h80});
      check("model -65<<1", model(8'hBF, 3'd1), {1'b1, 8'h80});

      // Directed vectors.
      op(8'h03, 3'd2, 8'h0C, 1'b0);
      op(8'h01, 3'd7, 8'h7F, 1'b1);   // 128 is out of range
      op(8'hFF, 3'd7, 8'h80, 1'b0);   // exact minimum, no saturation
      op(8'h40, 3'd1, 8'h7F, 1'b1);
      op(8'hBF, 3'd1, 8'h80, 1'b1);
      op(8'hC0, 3'd1, 8'h80, 1'b0);
      op(8'h5A, 3'd0, 8'h5A, 1'b0);
      op(8'h81, 3'd3, 8'h80, 1'b1);

      // Backpressure with ignored input pulses.
      start_op(8'h40, 3'd1);
      for (int i = 0; i < 5; i++) begin
         a = 8'h33; s = 3'd2; in_valid = (i % 2 == 0);
         @(posedge clk); #1;
         check("bp out_valid", out_valid, 1);
         check("bp res", res, 8'h7F);
         check("bp ovf", ovf, 1);
         check("bp in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      finish_op(0);
      repeat (3) begin
         @(posedge clk); #1;
         check("no extra result", out_valid, 0);
      end

      // Reset in the middle of SHIFT: in_valid seen in cycle T, rst in T+3.
      a = 8'h11; s = 3'd6; in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 50) begin
         @(posedge clk); #1; k++;
      end
      @(posedge clk); #1;            // cycle T+1
      in_valid = 1'b0;
      @(posedge clk); #1;            // cycle T+2
      @(posedge clk); #1;            // cycle T+3
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid rst out_valid", out_valid, 0);
      check("mid rst res", res, 8'h00);
      check("mid rst ovf", ovf, 0);
      check("mid rst in_ready", in_ready, 1);
      op(8'h02, 3'd3, 8'h10, 1'b0);

      // Exhaustive regression with random gaps and random out_ready.
      for (int ai = 0; ai < 256; ai++) begin
         for (int si = 0; si < 8; si++) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
            end
            start_op(8'(ai), 3'(si));
            k = 0;
            hs = 1'b0;
            while (!hs && k < 60) begin
               out_ready = 1'($urandom_range(0, 1));
               hs = out_valid && out_ready;
               @(posedge clk); #1;
               k++;
            end
            out_ready = 1'b0;
            check("regression drain", hs, 1);
         end
      end

      repeat (4) @(posedge clk);
      check("queue empty at end", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
